// File: rtl/bl_access_pkg.sv
// bl_access_pkg: shared state type, default BL geometry and select decoding for bl_access_ctrl
package bl_access_pkg;
  typedef enum logic [1:0] {IDLE, PRE, SENSE, RESP} state_t;
  localparam int DEF_NUM_BL = 9;
  localparam int DEF_BL_IDX_W = 4;
  localparam int DEF_PRE_CYC = 2;
  localparam int DEF_SENSE_CYC = 3;
  localparam int MAX_BL = 256;
  function automatic logic [MAX_BL-1:0] idx_onehot(input logic [7:0] idx);
    return MAX_BL'(1) << idx;
  endfunction
endpackage

// File: rtl/bl_access_ctrl_if.sv
// bl_access_ctrl_if: requester, response and BL pin bundle of bl_access_ctrl
interface bl_access_ctrl_if #(
  parameter int NUM_REQ = 3,
  parameter int NUM_BL = 9,
  parameter int BL_IDX_W = 4
);
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*BL_IDX_W-1:0] req_bl_idx;
  logic [NUM_REQ-1:0] req_ready;
  logic bl_pre;
  logic [NUM_BL-1:0] bl_sel;
  logic bl_sense;
  logic [NUM_BL-1:0] bl_in;
  logic rsp_valid;
  logic rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic rsp_data;
  logic rsp_err;
  modport master (
    output req_valid, req_bl_idx, bl_in, rsp_ready,
    input req_ready, bl_pre, bl_sel, bl_sense, rsp_valid, rsp_id, rsp_data, rsp_err
  );
  modport slave (
    input req_valid, req_bl_idx, bl_in, rsp_ready,
    output req_ready, bl_pre, bl_sel, bl_sense, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/bl_access_ctrl_arb.sv
// rr_arbiter: picks the first requester at or after ptr, wrapping at NUM_REQ
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input logic [NUM_REQ-1:0] req,
  input logic [ID_W-1:0] ptr,
  input logic enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0] grant_id
);
  logic [ID_W-1:0] k;
  logic found;
  always_comb begin
    grant = '0;
    grant_id = '0;
    found = 1'b0;
    k = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (enable && !found && req[k]) begin
        found = 1'b1;
        grant[k] = 1'b1;
        grant_id = k;
      end
      k = (k == ID_W'(NUM_REQ - 1)) ? '0 : k + ID_W'(1);
    end
  end
endmodule

// File: rtl/bl_access_ctrl.sv
// bl_access_ctrl: round-robin sequencer driving precharge/select/sense on the blk BL pins
module bl_access_ctrl
  import bl_access_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int NUM_BL = DEF_NUM_BL,
  parameter int BL_IDX_W = DEF_BL_IDX_W,
  parameter int PRE_CYC = DEF_PRE_CYC,
  parameter int SENSE_CYC = DEF_SENSE_CYC
) (
  input logic clk,
  input logic rst,
  bl_access_ctrl_if.slave bus
);
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2((PRE_CYC > SENSE_CYC ? PRE_CYC : SENSE_CYC) + 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0] rr_ptr, lat_id, grant_id;
  logic [BL_IDX_W-1:0] lat_idx, win_idx;
  logic [NUM_REQ-1:0] grant;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(bus.req_valid),
    .ptr(rr_ptr),
    .enable(state == IDLE && !rst),
    .grant(grant),
    .grant_id(grant_id)
  );
  assign bus.req_ready = grant;
  assign win_idx = bus.req_bl_idx[int'(grant_id)*BL_IDX_W +: BL_IDX_W];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rr_ptr <= '0;
      lat_id <= '0;
      lat_idx <= '0;
      bus.bl_pre <= 1'b0;
      bus.bl_sel <= '0;
      bus.bl_sense <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_data <= 1'b0;
      bus.rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|grant) begin
          lat_id <= grant_id;
          lat_idx <= win_idx;
          rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
          // out-of-range index answers immediately and never touches the array
          if (int'(win_idx) >= NUM_BL) begin
            state <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err <= 1'b1;
            bus.rsp_data <= 1'b0;
            bus.rsp_id <= grant_id;
          end else begin
            state <= PRE;
            cnt <= CNT_W'(PRE_CYC);
            bus.bl_pre <= 1'b1;
            bus.bl_sel <= NUM_BL'(idx_onehot(8'(win_idx)));
          end
        end
        PRE: if (cnt == CNT_W'(1)) begin
          state <= SENSE;
          cnt <= CNT_W'(SENSE_CYC);
          bus.bl_pre <= 1'b0;
          bus.bl_sense <= 1'b1;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        SENSE: if (cnt == CNT_W'(1)) begin
          state <= RESP;
          bus.bl_sense <= 1'b0;
          bus.bl_sel <= '0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_id <= lat_id;
          bus.rsp_data <= bus.bl_in[lat_idx];
          bus.rsp_err <= 1'b0;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        RESP: if (bus.rsp_ready) begin
          state <= IDLE;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
